// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/DRAIN sequencer feeding a one-entry
// valid/ready output register. Define FETCH_REDIRECT_EN to add the PC redirect port.
module fetch_ctrl #(
  parameter int MEM_DEPTH = 128,
  parameter int RESET_PC  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
`ifdef FETCH_REDIRECT_EN
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`endif
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        busy,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PC_INIT = AW'(RESET_PC % MEM_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] pc;
  logic          redir;
  logic          xfer;
  logic          capture;

  assign busy     = (state == S_FETCH) || (state == S_DRAIN);
  assign mem_addr = 32'(pc);

`ifdef FETCH_REDIRECT_EN
  logic [AW-1:0] redir_pc;
  logic          unused_redir_bits;
  assign redir             = busy & redirect_valid;
  assign redir_pc          = redirect_pc[AW-1:0];
  assign unused_redir_bits = ^redirect_pc[31:AW];
`else
  assign redir = 1'b0;
`endif

  // A redirect flushes the held word, so it must not also count as a transfer.
  assign xfer    = if_valid & if_ready & ~redir;
  assign capture = (state == S_FETCH) & ~redir & ~halt & (~if_valid | xfer);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (redir)     state_nxt = S_FETCH;
        else if (halt) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (redir)                  state_nxt = S_FETCH;
        else if (!if_valid || xfer) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= PC_INIT;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      fetch_count <= '0;
    end else begin
      state <= state_nxt;
      if (redir) begin
`ifdef FETCH_REDIRECT_EN
        pc       <= redir_pc;
`endif
        if_valid <= 1'b0;
      end else if (capture) begin
        if_instr <= mem_data;
        if_pc    <= 32'(pc);
        if_valid <= 1'b1;
        pc       <= pc + AW'(1);
      end else if (xfer) begin
        if_valid <= 1'b0;
      end
      if (xfer) fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
